// File: rtl/root_pkg.sv
// Shared widths and FSM state type for the root/remainder reconstruction unit.
// Widths are fixed: 16-bit root, 17-bit remainder, 32-bit radicand.
package root_pkg;

  localparam int QW = 16;
  localparam int RW = 17;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/root_square.sv
// Rebuilds d = q*q + r by 16 shift-add steps plus one add; ready rises 17 edges after load.
// No backpressure: a load in any state aborts the current operation and restarts it.
module root_square
  import root_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [QW-1:0] q,
  input  logic [RW-1:0] r,
  output logic [DW-1:0] d,
  output logic          ovf,
  output logic          rem_err,
  output logic          busy,
  output logic          ready,
  output logic [3:0]    count
);

  state_t        state_q,   state_d;
  logic [QW-1:0] mcand_q,   mcand_d;
  logic [QW-1:0] mplier_q,  mplier_d;
  logic [RW-1:0] rem_q,     rem_d;
  logic [DW:0]   acc_q,     acc_d;
  logic [3:0]    count_q,   count_d;
  logic          busy_q,    busy_d;
  logic          ready_q,   ready_d;
  logic [DW-1:0] d_q,       d_d;
  logic          ovf_q,     ovf_d;
  logic          rem_err_q, rem_err_d;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    count_d   = count_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    d_d       = d_q;
    ovf_d     = ovf_q;
    rem_err_d = rem_err_q;

    if (load) begin
      state_d   = ST_MUL;
      mcand_d   = q;
      mplier_d  = q;
      rem_d     = r;
      acc_d     = '0;
      count_d   = '0;
      busy_d    = 1'b1;
      ready_d   = 1'b0;
      d_d       = '0;
      ovf_d     = 1'b0;
      rem_err_d = (r > {q, 1'b0});
    end else begin
      case (state_q)
        ST_MUL: begin
          // Partial product never exceeds 32 bits, so dropping acc[32] on the shift is safe.
          acc_d    = {acc_q[DW-1:0], 1'b0}
                   + (mplier_q[QW-1] ? {{(DW+1-QW){1'b0}}, mcand_q} : '0);
          mplier_d = {mplier_q[QW-2:0], 1'b0};
          count_d  = count_q + 4'd1;
          if (count_q == 4'hF) state_d = ST_ADD;
        end
        ST_ADD: begin
          acc_d   = acc_q + {{(DW+1-RW){1'b0}}, rem_q};
          state_d = ST_DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          d_d     = acc_d[DW-1:0];
          ovf_d   = acc_d[DW];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      d_q       <= '0;
      ovf_q     <= 1'b0;
      rem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      d_q       <= d_d;
      ovf_q     <= ovf_d;
      rem_err_q <= rem_err_d;
    end
  end

  assign d       = d_q;
  assign ovf     = ovf_q;
  assign rem_err = rem_err_q;
  assign busy    = busy_q;
  assign ready   = ready_q;
  assign count   = count_q;

endmodule
